// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences one-cycle registered memory
// reads, and presents fetched words through a 2-entry valid/ready queue.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] programcounter,
    input  logic [15:0] mem_instr,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_instr,
    output logic [15:0] ir_pc,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    // Handshake: a word transfers on any clock edge where ir_valid && ir_ready;
    // ir_instr/ir_pc stay stable while ir_valid is high and ir_ready is low.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [15:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
    logic [15:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        e0_instr_d    = e0_instr_q;
        e0_pc_d       = e0_pc_q;
        e1_instr_d    = e1_instr_q;
        e1_pc_d       = e1_pc_q;

        pop       = (count_q != 2'd0) && ir_ready;
        // Slots the queue will need after this edge, counting the word already in flight.
        occupancy = 3'(count_q) - 3'(pop) + 3'(inflight_q);
        issue     = (state_q == RUN) && !branch_valid && (occupancy < 3'd2);
        // Words arriving while halting are the ones fetched behind the halt word.
        push      = inflight_q && (state_q == RUN) && !branch_valid;

        if (branch_valid) begin
            count_d    = 2'd0;
            fetch_pc_d = {branch_target[15:1], 1'b0};
            state_d    = RUN;
        end else begin
            if (pop) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
                count_d    = count_q - 2'd1;
            end
            if (push) begin
                if (count_d == 2'd0) begin
                    e0_instr_d = mem_instr;
                    e0_pc_d    = inflight_pc_q;
                end else begin
                    e1_instr_d = mem_instr;
                    e1_pc_d    = inflight_pc_q;
                end
                count_d = count_d + 2'd1;
                if (mem_instr[15:12] == HALT_OPCODE) begin
                    state_d = HALTING;
                end
            end
            // Nothing is pushed while halting, so the last entry leaving is the halt word.
            if ((state_q == HALTING) && pop && (count_q == 2'd1)) begin
                state_d = HALTED;
            end
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
            count_q       <= 2'd0;
            e0_instr_q    <= 16'h0000;
            e0_pc_q       <= 16'h0000;
            e1_instr_q    <= 16'h0000;
            e1_pc_q       <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            e0_instr_q    <= e0_instr_d;
            e0_pc_q       <= e0_pc_d;
            e1_instr_q    <= e1_instr_d;
            e1_pc_q       <= e1_pc_d;
        end
    end

    assign programcounter = fetch_pc_q;
    assign ir_valid       = (count_q != 2'd0);
    assign ir_instr       = e0_instr_q;
    assign ir_pc          = e0_pc_q;
    assign halted         = (state_q == HALTED);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: registered memory model, expected-stream
// scoreboard checked on every accepted transfer, plus point checks per scenario.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] programcounter;
    logic [15:0] mem_instr;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_instr;
    logic [15:0] ir_pc;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        halted;
    logic [1:0]  dbg_state;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        halt_en = 1'b0;
    logic [31:0] exp_q[$];

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .programcounter (programcounter),
        .mem_instr      (mem_instr),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    // ---- clock / reset block ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- memory model: one-cycle registered read ----
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        if (halt_en && addr == 16'h0006) return 16'hF123;
        return 16'h1000 + addr;
    endfunction

    initial mem_instr = 16'h0000;
    always @(posedge clk) mem_instr <= mem_word(programcounter);

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, mem_word(a)});
            a = a + 16'd2;
        end
    endtask

    // One clock: score the transfer about to happen, then advance to #1 after the edge.
    task automatic step();
        logic [31:0] e;
        if (ir_valid && ir_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(ir_pc), 32'(e[31:16]));
                check("sb_instr", 32'(ir_instr), 32'(e[15:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [15:0] target);
        branch_valid  = 1'b1;
        branch_target = target;
        step();
        branch_valid  = 1'b0;
        exp_q.delete();
    endtask

    // ---- directed sequence ----
    initial begin
        logic [15:0] held_instr;
        logic [15:0] held_pc;

        rst           = 1'b0;
        ir_ready      = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir_instr", 32'(ir_instr), 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(programcounter), 32'h0000);
        check("rst_state", 32'(dbg_state), 32'd0);

        // 1: startup stream
        push_stream(16'h0000, 40);
        ir_ready = 1'b1;
        rst      = 1'b1;
        step();
        check("t1_pc_after1", 32'(programcounter), 32'h0002);
        check("t1_valid_after1", 32'(ir_valid), 32'd0);
        step();
        check("t1_pc_after2", 32'(programcounter), 32'h0004);
        check("t1_valid_after2", 32'(ir_valid), 32'd1);
        check("t1_first_pc", 32'(ir_pc), 32'h0000);
        check("t1_first_instr", 32'(ir_instr), 32'h1000);
        step();
        check("t1_second_pc", 32'(ir_pc), 32'h0002);
        step();
        check("t1_third_pc", 32'(ir_pc), 32'h0004);
        check("t1_third_instr", 32'(ir_instr), 32'h1004);
        repeat (3) step();

        // 2: downstream stall
        ir_ready   = 1'b0;
        held_instr = ir_instr;
        step();
        held_pc = programcounter;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_instr_stable", 32'(ir_instr), 32'(held_instr));
            check("t2_pc_frozen", 32'(programcounter), 32'(held_pc));
        end
        ir_ready = 1'b1;
        repeat (6) step();

        // 3: branch while queue full
        ir_ready = 1'b0;
        repeat (3) step();
        check("t3_full_valid", 32'(ir_valid), 32'd1);
        do_branch(16'h0041);
        push_stream(16'h0040, 20);
        check("t3_valid_drop", 32'(ir_valid), 32'd0);
        check("t3_pc_target", 32'(programcounter), 32'h0040);
        ir_ready = 1'b1;
        step();
        check("t3_valid_gap", 32'(ir_valid), 32'd0);
        step();
        check("t3_first_valid", 32'(ir_valid), 32'd1);
        check("t3_first_pc", 32'(ir_pc), 32'h0040);
        repeat (4) step();

        // 4: halt opcode at 0006
        halt_en = 1'b1;
        do_branch(16'h0000);
        exp_q.push_back({16'h0000, 16'h1000});
        exp_q.push_back({16'h0002, 16'h1002});
        exp_q.push_back({16'h0004, 16'h1004});
        exp_q.push_back({16'h0006, 16'hF123});
        for (int i = 0; i < 12 && !(ir_valid && ir_pc == 16'h0006); i++) step();
        check("t4_halt_word_pc", 32'(ir_pc), 32'h0006);
        check("t4_halt_word_instr", 32'(ir_instr), 32'hF123);
        check("t4_not_yet_halted", 32'(halted), 32'd0);
        step();
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_state_halted", 32'(dbg_state), 32'd2);
        check("t4_valid_off", 32'(ir_valid), 32'd0);
        held_pc = programcounter;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_no_valid", 32'(ir_valid), 32'd0);
            check("t4_pc_frozen", 32'(programcounter), 32'(held_pc));
        end
        check("t4_sb_drained", 32'(exp_q.size()), 32'd0);
        halt_en = 1'b0;
        do_branch(16'h0010);
        push_stream(16'h0010, 20);
        check("t4_unhalted", 32'(halted), 32'd0);
        step();
        step();
        check("t4_resume_pc", 32'(ir_pc), 32'h0010);
        repeat (3) step();

        // 5: wrap at top of address space
        do_branch(16'hFFFC);
        push_stream(16'hFFFC, 10);
        step();
        step();
        check("t5_first_pc", 32'(ir_pc), 32'hFFFC);
        step();
        check("t5_second_pc", 32'(ir_pc), 32'hFFFE);
        step();
        check("t5_wrap_pc", 32'(ir_pc), 32'h0000);
        check("t5_wrap_instr", 32'(ir_instr), 32'h1000);
        repeat (3) step();

        // 6: asynchronous reset with queue full
        ir_ready = 1'b0;
        repeat (3) step();
        check("t6_full_valid", 32'(ir_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(ir_valid), 32'd0);
        check("t6_async_pc", 32'(programcounter), 32'h0000);
        check("t6_async_ir_pc", 32'(ir_pc), 32'h0000);
        check("t6_async_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        push_stream(16'h0000, 20);
        ir_ready = 1'b1;
        rst      = 1'b1;
        step();
        check("t6_restart_gap", 32'(ir_valid), 32'd0);
        step();
        check("t6_restart_pc", 32'(ir_pc), 32'h0000);
        check("t6_restart_instr", 32'(ir_instr), 32'h1000);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
